// File: rtl/fc_param_mac_if.sv
// Stream and weight-write bundle for the fully-connected MAC engine.
interface fc_param_mac_if #(
  parameter int unsigned T  = 16,
  parameter int unsigned AW = 5
);
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic signed [T-1:0] output_data;
  logic                wt_wr_en;
  logic [AW-1:0]       wt_addr;
  logic signed [T-1:0] wt_data;

  // Producer/consumer side driving the engine
  modport master (
    output input_valid, input_data, output_ready, wt_wr_en, wt_addr, wt_data,
    input  input_ready, output_valid, output_data
  );

  // Engine side
  modport slave (
    input  input_valid, input_data, output_ready, wt_wr_en, wt_addr, wt_data,
    output input_ready, output_valid, output_data
  );
endinterface

// File: rtl/fc_param_mac.sv
// Fully-connected layer engine: y = W*x with P parallel MAC lanes,
// run-time writable banked weight RAM, rescale, saturation and optional ReLU.
module fc_param_mac #(
  parameter int unsigned M    = 4,
  parameter int unsigned N    = 8,
  parameter int unsigned T    = 16,
  parameter int unsigned P    = 2,
  parameter int unsigned FRAC = 0,
  parameter int unsigned RELU = 0
) (
  input logic          clk,
  input logic          reset,
  fc_param_mac_if.slave bus
);

  localparam int unsigned PASSES = M / P;
  localparam int unsigned XW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned JW     = $clog2(N + 1);
  localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned LW     = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned BD     = PASSES * N;
  localparam int unsigned BAW    = (BD > 1) ? $clog2(BD) : 1;
  localparam int unsigned ACCW   = 2 * T + XW;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    MAC    = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t               state;
  logic [XW-1:0]        x_cnt;
  logic [JW-1:0]        j;
  logic [PW-1:0]        pass;
  logic [LW-1:0]        k;
  logic                 out_valid;
  logic signed [T-1:0]  out_data;

  logic signed [T-1:0]    xmem [N];
  logic signed [T-1:0]    x_rd;
  logic signed [ACCW-1:0] acc     [P];
  logic signed [ACCW-1:0] acc_nxt [P];

  logic           in_fire;
  logic           issue;
  logic [BAW-1:0] rd_addr;

  logic [31:0]    wr_a32;
  logic [31:0]    wr_row;
  logic [31:0]    wr_bank;
  logic [BAW-1:0] wr_local;
  logic           wr_ok;

  // Shift, saturate to T bits, then optionally clamp negatives
  function automatic logic signed [T-1:0] rescale(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] v;
    v = a >>> FRAC;
    if (v > SAT_MAX) begin
      v = SAT_MAX;
    end else if (v < SAT_MIN) begin
      v = SAT_MIN;
    end
    if ((RELU != 0) && v[ACCW-1]) begin
      v = '0;
    end
    return T'(v);
  endfunction

  assign bus.input_ready  = (state == LOAD_X) && reset;
  assign bus.output_valid = out_valid;
  assign bus.output_data  = out_data;

  assign in_fire = bus.input_valid && bus.input_ready;
  assign issue   = (state == MAC) && (j < JW'(N));
  assign rd_addr = BAW'(32'(pass) * N + 32'(j));

  // Weight index r*N+c maps to bank r%P, local row r/P
  assign wr_a32   = 32'(bus.wt_addr);
  assign wr_row   = wr_a32 / N;
  assign wr_bank  = wr_row % P;
  assign wr_local = BAW'((wr_row / P) * N + wr_a32 % N);
  assign wr_ok    = (state == LOAD_X) && bus.wt_wr_en && (wr_a32 < M * N);

  // Input vector RAM write port
  always_ff @(posedge clk) begin
    if (in_fire) begin
      xmem[x_cnt] <= bus.input_data;
    end
  end

  // Input vector RAM synchronous read, shared by all lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_rd <= '0;
    end else if (issue) begin
      x_rd <= xmem[j[XW-1:0]];
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_bank
    logic signed [T-1:0]   mem [BD];
    logic signed [T-1:0]   w_rd;
    logic signed [2*T-1:0] prod;

    // Bank write port, rows r with r%P == p
    always_ff @(posedge clk) begin
      if (wr_ok && (wr_bank == 32'(p))) begin
        mem[wr_local] <= bus.wt_data;
      end
    end

    // Bank synchronous read of row pass*P+p
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        w_rd <= '0;
      end else if (issue) begin
        w_rd <= mem[rd_addr];
      end
    end

    assign prod       = (2*T)'(x_rd) * (2*T)'(w_rd);
    assign acc_nxt[p] = acc[p] + ACCW'(prod);
  end

  // Control FSM with accumulators and registered output stream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_X;
      x_cnt     <= '0;
      j         <= '0;
      pass      <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int p = 0; p < P; p++) begin
        acc[p] <= '0;
      end
    end else begin
      case (state)
        LOAD_X: begin
          if (in_fire) begin
            if (x_cnt == XW'(N - 1)) begin
              x_cnt <= '0;
              state <= MAC;
              pass  <= '0;
              j     <= '0;
              for (int p = 0; p < P; p++) begin
                acc[p] <= '0;
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end

        MAC: begin
          // Read data for address j-1 arrives on cycle j
          if (j != '0) begin
            for (int p = 0; p < P; p++) begin
              acc[p] <= acc_nxt[p];
            end
          end
          if (j == JW'(N)) begin
            state     <= OUT;
            k         <= '0;
            out_valid <= 1'b1;
            out_data  <= rescale(acc_nxt[0]);
          end else begin
            j <= j + 1'b1;
          end
        end

        OUT: begin
          if (out_valid && bus.output_ready) begin
            if (k == LW'(P - 1)) begin
              out_valid <= 1'b0;
              k         <= '0;
              if (pass == PW'(PASSES - 1)) begin
                state <= LOAD_X;
                x_cnt <= '0;
              end else begin
                pass  <= pass + 1'b1;
                j     <= '0;
                state <= MAC;
                for (int p = 0; p < P; p++) begin
                  acc[p] <= '0;
                end
              end
            end else begin
              k        <= k + 1'b1;
              out_data <= rescale(acc[k + 1'b1]);
            end
          end
        end

        default: begin
          state <= LOAD_X;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_param_mac.sv
// Directed bench: three engine builds (plain, FRAC=1, RELU=1) share one stimulus.
module tb_fc_param_mac;

  localparam int unsigned M  = 4;
  localparam int unsigned N  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned P  = 2;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fc_param_mac_if #(.T(T), .AW(AW)) if_f0 ();
  fc_param_mac_if #(.T(T), .AW(AW)) if_f1 ();
  fc_param_mac_if #(.T(T), .AW(AW)) if_r1 ();

  assign if_f1.input_valid  = if_f0.input_valid;
  assign if_f1.input_data   = if_f0.input_data;
  assign if_f1.output_ready = if_f0.output_ready;
  assign if_f1.wt_wr_en     = if_f0.wt_wr_en;
  assign if_f1.wt_addr      = if_f0.wt_addr;
  assign if_f1.wt_data      = if_f0.wt_data;
  assign if_r1.input_valid  = if_f0.input_valid;
  assign if_r1.input_data   = if_f0.input_data;
  assign if_r1.output_ready = if_f0.output_ready;
  assign if_r1.wt_wr_en     = if_f0.wt_wr_en;
  assign if_r1.wt_addr      = if_f0.wt_addr;
  assign if_r1.wt_data      = if_f0.wt_data;

  fc_param_mac #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(0)) u_f0 (
    .clk(clk), .reset(reset), .bus(if_f0));
  fc_param_mac #(.M(M), .N(N), .T(T), .P(P), .FRAC(1), .RELU(0)) u_f1 (
    .clk(clk), .reset(reset), .bus(if_f1));
  fc_param_mac #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(1)) u_r1 (
    .clk(clk), .reset(reset), .bus(if_r1));

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int mac_entry = 0;

  logic signed [T-1:0] xv [N];
  int e0 [M];
  int e1 [M];
  int e2 [M];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: every weight = val; mode 1: row r weight = r+1
  task automatic load_w(input int mode, input int val);
    for (int a = 0; a < int'(M * N); a++) begin
      @(negedge clk);
      if_f0.wt_wr_en = 1'b1;
      if_f0.wt_addr  = AW'(a);
      if_f0.wt_data  = (mode == 0) ? T'(val) : T'(a / int'(N) + 1);
    end
    @(negedge clk);
    if_f0.wt_wr_en = 1'b0;
  endtask

  // mode 0: x = 1..N; mode 1: every element = v
  task automatic set_x(input int mode, input int v);
    for (int i = 0; i < int'(N); i++) xv[i] = (mode == 0) ? T'(i + 1) : T'(v);
  endtask

  task automatic set_exp(input int v0, input int v1, input int v2, input bit rowscale);
    for (int i = 0; i < int'(M); i++) begin
      e0[i] = rowscale ? v0 * (i + 1) : v0;
      e1[i] = rowscale ? v1 * (i + 1) : v1;
      e2[i] = rowscale ? v2 * (i + 1) : v2;
    end
  endtask

  task automatic send_vec();
    int i = 0;
    int guard = 0;
    while (i < int'(N) && guard < 200) begin
      @(negedge clk);
      guard++;
      if_f0.input_valid = 1'b1;
      if_f0.input_data  = xv[i];
      if (if_f0.input_ready) i++;
    end
    chk("send_done", i, N);
    mac_entry = cyc + 1;
    @(negedge clk);
    if_f0.input_valid = 1'b0;
  endtask

  task automatic collect(input int first, input int cnt, input bit spacing);
    for (int idx = first; idx < first + cnt; idx++) begin
      int guard = 0;
      while (!if_f0.output_valid && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk($sformatf("y%0d_valid", idx), if_f0.output_valid, 1);
      if (spacing && (idx % int'(P)) == 0)
        chk($sformatf("y%0d_mac_to_out", idx), cyc - mac_entry, N + 1);
      chk($sformatf("y%0d_f0", idx), if_f0.output_data, e0[idx]);
      chk($sformatf("y%0d_f1", idx), if_f1.output_data, e1[idx]);
      chk($sformatf("y%0d_r1", idx), if_r1.output_data, e2[idx]);
      if ((idx % int'(P)) == int'(P) - 1) mac_entry = cyc + 1;
      @(negedge clk);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid_low"}, if_f0.output_valid, 0);
    chk({tag, "_ready_high"}, if_f0.input_ready, 1);
  endtask

  task automatic run_vec(input string tag);
    send_vec();
    collect(0, M, 1'b1);
    idle_chk(tag);
  endtask

  initial begin
    reset              = 1'b0;
    if_f0.input_valid  = 1'b0;
    if_f0.input_data   = '0;
    if_f0.output_ready = 1'b1;
    if_f0.wt_wr_en     = 1'b0;
    if_f0.wt_addr      = '0;
    if_f0.wt_data      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_input_ready", if_f0.input_ready, 0);
    chk("rst_output_valid", if_f0.output_valid, 0);
    chk("rst_output_data", if_f0.output_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_input_ready", if_f0.input_ready, 1);

    // All weights 1, x = 1..8
    load_w(0, 1);
    set_x(0, 0);
    set_exp(36, 18, 36, 1'b0);
    run_vec("ones");

    // Backpressure on y[0]
    if_f0.output_ready = 1'b0;
    send_vec();
    begin
      int guard = 0;
      while (!if_f0.output_valid && guard < 100) begin
        @(negedge clk);
        guard++;
      end
    end
    for (int h = 0; h < 5; h++) begin
      chk($sformatf("bp%0d_valid", h), if_f0.output_valid, 1);
      chk($sformatf("bp%0d_data", h), if_f0.output_data, 36);
      chk($sformatf("bp%0d_in_ready", h), if_f0.input_ready, 0);
      @(negedge clk);
    end
    if_f0.output_ready = 1'b1;
    collect(0, M, 1'b0);
    idle_chk("bp");

    // Row r weight r+1, x all 2
    load_w(1, 0);
    set_x(1, 2);
    set_exp(16, 8, 16, 1'b1);
    run_vec("rows");

    // Positive and negative saturation
    load_w(0, 32767);
    set_x(1, 32767);
    set_exp(32767, 32767, 32767, 1'b0);
    run_vec("sat_pos");
    set_x(1, -32768);
    set_exp(-32768, -32768, 0, 1'b0);
    run_vec("sat_neg");

    // Negative weights: ReLU clamps, others keep sign
    load_w(0, -1);
    set_x(0, 0);
    set_exp(-36, -18, 0, 1'b0);
    run_vec("neg");

    load_w(0, 1);
    set_exp(36, 18, 36, 1'b0);
    run_vec("pos");

    // Reset during second MAC pass
    send_vec();
    collect(0, 2, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_output_valid", if_f0.output_valid, 0);
    chk("midrst_output_data", if_f0.output_data, 0);
    chk("midrst_input_ready", if_f0.input_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_chk("after_rst");

    // New vector with weight writes attempted during MAC
    send_vec();
    if_f0.wt_wr_en = 1'b1;
    if_f0.wt_data  = T'(100);
    if_f0.wt_addr  = AW'(16);
    @(negedge clk);
    if_f0.wt_addr  = AW'(19);
    @(negedge clk);
    if_f0.wt_addr  = AW'(27);
    @(negedge clk);
    if_f0.wt_wr_en = 1'b0;
    collect(0, M, 1'b1);
    idle_chk("wr_in_mac");

    // Weights still all ones
    set_x(1, 1);
    set_exp(8, 4, 8, 1'b0);
    run_vec("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
